// File: rtl/hold_pkg.sv
// Hold-flag codes and per-stage flush/stall masks shared by every pipeline stage boundary.
package hold_pkg;

  localparam int HOLD_W = 3;
  localparam int MASK_W = 1 << HOLD_W;

  typedef enum logic [HOLD_W-1:0] {
    HOLD_NONE  = 3'd0,
    HOLD_CODE1 = 3'd1,
    HOLD_CODE2 = 3'd2,
    HOLD_CODE3 = 3'd3,
    HOLD_CODE4 = 3'd4,
    HOLD_CODE5 = 3'd5,
    HOLD_CODE6 = 3'd6,
    HOLD_CODE7 = 3'd7
  } hold_code_e;

  // Bit k of a mask selects hold code k; when a code sits in both masks, flush wins.
  localparam logic [MASK_W-1:0] IFID_FLUSH_MASK  = 8'h1E;
  localparam logic [MASK_W-1:0] IFID_STALL_MASK  = 8'hE0;
  localparam logic [MASK_W-1:0] IDEX_FLUSH_MASK  = 8'h1E;
  localparam logic [MASK_W-1:0] IDEX_STALL_MASK  = 8'hE0;
  localparam logic [MASK_W-1:0] EXMEM_FLUSH_MASK = 8'h1C;
  localparam logic [MASK_W-1:0] EXMEM_STALL_MASK = 8'hE0;
  localparam logic [MASK_W-1:0] MEMWB_FLUSH_MASK = 8'h18;
  localparam logic [MASK_W-1:0] MEMWB_STALL_MASK = 8'hC0;

endpackage

// File: rtl/sat_counter.sv
// Saturating accumulator: adds 0..3 per enabled cycle and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [1:0]       inc_amt,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W:0] MAX_EXT = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W:0] sum;

  assign sum = {1'b0, count} + (CNT_W+1)'(inc_amt);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc_en) begin
      count <= (sum > MAX_EXT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// One pipeline-stage boundary: valid/ready handshake with a 2-entry skid FIFO,
// hold-flag driven flush/stall, and a saturating count of beats lost to flushes.
module pipe_stage_skid #(
  parameter int                          WIDTH      = 32,
  parameter logic [WIDTH-1:0]            RESET_VAL  = '0,
  parameter int                          HOLD_W     = hold_pkg::HOLD_W,
  parameter logic [(1 << HOLD_W)-1:0]    FLUSH_MASK = hold_pkg::IFID_FLUSH_MASK,
  parameter logic [(1 << HOLD_W)-1:0]    STALL_MASK = hold_pkg::IFID_STALL_MASK,
  parameter int                          CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HOLD_W-1:0] hold_flag,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_drops
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] skid;
  logic [1:0]       occ;
  logic             flush_hit;
  logic             stall_hit;
  logic             push;
  logic             pop;

  assign flush_hit = FLUSH_MASK[hold_flag];
  assign stall_hit = STALL_MASK[hold_flag] & ~flush_hit;

  assign in_ready  = (occ < 2'd2) & ~flush_hit & ~stall_hit;
  assign out_valid = (occ != 2'd0) & ~flush_hit & ~stall_hit;
  assign out_data  = head;
  assign occupancy = occ;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Empty slots are always rewritten to RESET_VAL so out_data needs no muxing when empty.
  always_ff @(posedge clk) begin
    if (rst || flush_hit) begin
      head <= RESET_VAL;
      skid <= RESET_VAL;
      occ  <= 2'd0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            head <= in_data;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= in_data;
          end else if (push) begin
            skid <= in_data;
            occ  <= 2'd2;
          end else if (pop) begin
            head <= RESET_VAL;
            occ  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head <= skid;
            skid <= RESET_VAL;
            occ  <= 2'd1;
          end
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_drops (
    .clk    (clk),
    .rst    (rst),
    .inc_en (flush_hit),
    .inc_amt(occ),
    .count  (flush_drops)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives three differently configured stages with one stimulus stream and checks
// each against a queue-based model of the FIFO, flush and drop-count rules.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hold_flag;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        rdy [3];
  logic        vld [3];
  logic [31:0] dat [3];
  logic [1:0]  occ [3];
  logic [7:0]  drp [3];
  logic [1:0]  drops2;

  logic [7:0]  fmask [3];
  logic [7:0]  smask [3];
  int          cmax  [3];

  logic [31:0] sbq [3][$];
  int          mcnt [3];
  bit          armed = 1'b0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.WIDTH(32), .RESET_VAL(32'h0), .HOLD_W(3),
    .FLUSH_MASK(8'h1E), .STALL_MASK(8'hE0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .hold_flag(hold_flag), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .out_valid(vld[0]), .out_data(dat[0]), .out_ready(out_ready),
    .occupancy(occ[0]), .flush_drops(drp[0]));

  pipe_stage_skid #(.WIDTH(32), .RESET_VAL(32'h0), .HOLD_W(3),
    .FLUSH_MASK(8'h20), .STALL_MASK(8'h20), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .hold_flag(hold_flag), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .out_valid(vld[1]), .out_data(dat[1]), .out_ready(out_ready),
    .occupancy(occ[1]), .flush_drops(drp[1]));

  pipe_stage_skid #(.WIDTH(32), .RESET_VAL(32'h0), .HOLD_W(3),
    .FLUSH_MASK(8'h1E), .STALL_MASK(8'hE0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .hold_flag(hold_flag), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[2]), .out_valid(vld[2]), .out_data(dat[2]), .out_ready(out_ready),
    .occupancy(occ[2]), .flush_drops(drops2));

  assign drp[2] = {6'b0, drops2};

  initial begin
    fmask[0] = 8'h1E; smask[0] = 8'hE0; cmax[0] = 255;
    fmask[1] = 8'h20; smask[1] = 8'h20; cmax[1] = 255;
    fmask[2] = 8'h1E; smask[2] = 8'hE0; cmax[2] = 3;
    for (int k = 0; k < 3; k++) mcnt[k] = 0;
  end

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s dut%0d t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
    end
  endtask

  // Compares one instance against the model, then advances the model for the coming edge.
  task automatic checkOutput(input int k);
    bit f, s, eready, evalid;
    int sz, sum;
    f = fmask[k][hold_flag];
    s = smask[k][hold_flag] && !f;
    sz = sbq[k].size();
    eready = (sz < 2) && !f && !s;
    evalid = (sz != 0) && !f && !s;
    if (armed) begin
      chk("in_ready", k, longint'(rdy[k]), longint'(eready));
      chk("out_valid", k, longint'(vld[k]), longint'(evalid));
      chk("occupancy", k, longint'(occ[k]), longint'(sz));
      chk("flush_drops", k, longint'(drp[k]), longint'(mcnt[k]));
      chk("out_data", k, longint'(dat[k]), (sz != 0) ? longint'(sbq[k][0]) : 64'd0);
    end
    if (rst) begin
      sbq[k].delete();
      mcnt[k] = 0;
    end else if (f) begin
      sum = mcnt[k] + sz;
      mcnt[k] = (sum > cmax[k]) ? cmax[k] : sum;
      sbq[k].delete();
    end else begin
      if (evalid && out_ready) void'(sbq[k].pop_front());
      if (eready && in_valid) sbq[k].push_back(in_data);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) checkOutput(k);
    if (rst) armed = 1'b1;
  end

  task automatic applyStimulus(input logic r, input logic [2:0] h, input logic v,
                               input logic [31:0] d, input logic o);
    rst = r; hold_flag = h; in_valid = v; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; hold_flag = 3'd0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    // streaming
    applyStimulus(0, 0, 1, 32'hA1, 1);
    applyStimulus(0, 0, 1, 32'hA2, 1);
    applyStimulus(0, 0, 1, 32'hA3, 1);
    applyStimulus(0, 0, 0, 0, 1);
    // backpressure, third beat refused while full
    applyStimulus(0, 0, 1, 32'h11, 0);
    applyStimulus(0, 0, 1, 32'h22, 0);
    applyStimulus(0, 0, 1, 32'h99, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    // flush at occupancy 2 with a beat offered
    applyStimulus(0, 0, 1, 32'h55, 0);
    applyStimulus(0, 0, 1, 32'h66, 0);
    applyStimulus(0, 3, 1, 32'h33, 1);
    applyStimulus(0, 0, 0, 0, 0);
    // stall for three cycles, then release
    applyStimulus(0, 0, 1, 32'h44, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 6, 1, 32'h45, 1);
    applyStimulus(0, 0, 1, 32'h45, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    // code 5: stall on dut0/dut2, flush (overlap) on dut1
    applyStimulus(0, 0, 1, 32'h77, 0);
    applyStimulus(0, 5, 1, 32'h78, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    // saturation of the 2-bit counter
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 32'h100 + i, 0);
      applyStimulus(0, 0, 1, 32'h200 + i, 0);
      applyStimulus(0, 3, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    // reset on the same edge as a flush
    applyStimulus(0, 0, 1, 32'h1, 0);
    applyStimulus(1, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(99) == 0),
                    ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0,
                    1'($urandom_range(1)), $urandom,
                    ($urandom_range(3) != 0));
    end
    applyStimulus(0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
